// File: rtl/l1_ahb_mtx_dec_param.sv
// L1 bus-matrix input-stage decoder: address-region port select, data-phase response
// mux, two-cycle ERROR default slave and a saturating error log with address capture.
module l1_ahb_mtx_dec_param #(
    parameter int                  NPORT      = 3,
    parameter logic [NPORT*22-1:0] ADDR_BASE  = {22'h100000, 22'h080000, 22'h000000},
    parameter logic [NPORT*22-1:0] ADDR_LIMIT = {22'h10003f, 22'h08003f, 22'h00003f},
    parameter bit                  REMAP_EN   = 1'b0,
    parameter int                  REMAP_PORT = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HREADYS,
    input  logic                  sel_dec,
    input  logic [21:0]           decode_addr_dec,
    input  logic [1:0]            trans_dec,
    input  logic                  remap,
    input  logic                  err_clr,
    input  logic [NPORT-1:0]      active_in,
    input  logic [NPORT-1:0]      readyout_in,
    input  logic [2*NPORT-1:0]    resp_in,
    input  logic [32*NPORT-1:0]   rdata_in,
    input  logic [32*NPORT-1:0]   ruser_in,
    output logic [NPORT-1:0]      sel_out,
    output logic                  active_dec,
    output logic                  HREADYOUTS,
    output logic [1:0]            HRESPS,
    output logic [31:0]           HRDATAS,
    output logic [31:0]           HRUSERS,
    output logic [15:0]           err_count,
    output logic [21:0]           err_addr
);

    localparam logic [3:0] DEF_PORT = 4'(NPORT);

    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

    ds_state_t          state_reg, state_next;
    logic [3:0]         data_port_reg;
    logic [3:0]         hit_port;
    logic [3:0]         addr_port;
    logic [NPORT-1:0]   hit;
    logic               def_sel;
    logic               err_accept;
    logic               err_entry;
    logic [15:0]        err_count_reg;
    logic [21:0]        err_addr_reg;

    // A region whose base exceeds its limit can never hit, so it is disabled for free.
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_hit
        assign hit[gi] = (decode_addr_dec >= ADDR_BASE[22*gi +: 22]) &&
                         (decode_addr_dec <= ADDR_LIMIT[22*gi +: 22]);
        assign sel_out[gi] = sel_dec && (addr_port == 4'(gi));
    end

    always_comb begin
        hit_port = DEF_PORT;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (hit[i]) hit_port = 4'(i);
        end
        if (REMAP_EN && remap && hit[0]) hit_port = 4'(REMAP_PORT);
        addr_port = hit_port;
        // IDLE cycles stay parked on the port owning the data phase.
        if (trans_dec == 2'b00 && data_port_reg < DEF_PORT) addr_port = data_port_reg;
    end

    always_comb begin
        active_dec = 1'b1;
        for (int i = 0; i < NPORT; i++) begin
            if (addr_port == 4'(i)) active_dec = active_in[i];
        end
    end

    assign def_sel    = sel_dec && (addr_port == DEF_PORT);
    assign err_accept = def_sel && HREADYS && trans_dec[1];
    assign err_entry  = err_accept && (state_reg != DS_ERR1);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DS_IDLE: if (err_accept) state_next = DS_ERR1;
            DS_ERR1: state_next = DS_ERR2;
            DS_ERR2: state_next = err_accept ? DS_ERR1 : DS_IDLE;
            default: state_next = DS_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg     <= DS_IDLE;
            data_port_reg <= DEF_PORT;
        end else begin
            state_reg <= state_next;
            if (HREADYS) data_port_reg <= addr_port;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_count_reg <= 16'h0000;
            err_addr_reg  <= 22'h000000;
        end else begin
            if (err_clr) begin
                err_count_reg <= err_entry ? 16'h0001 : 16'h0000;
            end else if (err_entry && err_count_reg != 16'hFFFF) begin
                err_count_reg <= err_count_reg + 16'h0001;
            end
            if (err_entry) err_addr_reg <= decode_addr_dec;
        end
    end

    assign err_count = err_count_reg;
    assign err_addr  = err_addr_reg;

    always_comb begin
        HREADYOUTS = (state_reg != DS_ERR1);
        HRESPS     = (state_reg == DS_IDLE) ? 2'b00 : 2'b01;
        HRDATAS    = 32'h0;
        HRUSERS    = 32'h0;
        for (int i = 0; i < NPORT; i++) begin
            if (data_port_reg == 4'(i)) begin
                HREADYOUTS = readyout_in[i];
                HRESPS     = resp_in[2*i +: 2];
                HRDATAS    = rdata_in[32*i +: 32];
                HRUSERS    = ruser_in[32*i +: 32];
            end
        end
    end

endmodule

// File: tb/tb_l1_ahb_mtx_dec_param.sv
// Directed bench for l1_ahb_mtx_dec_param: decode vector table plus hand-written
// data-phase, default-slave, error-log, hold, wait-state and reset sequences.
module tb_l1_ahb_mtx_dec_param;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic         HREADYS;
    logic         sel_dec;
    logic [21:0]  decode_addr_dec;
    logic [1:0]   trans_dec;
    logic         remap;
    logic         err_clr;
    logic [2:0]   active_in;
    logic [2:0]   readyout_in;
    logic [5:0]   resp_in;
    logic [95:0]  rdata_in;
    logic [95:0]  ruser_in;
    logic [2:0]   sel_out;
    logic         active_dec;
    logic         HREADYOUTS;
    logic [1:0]   HRESPS;
    logic [31:0]  HRDATAS;
    logic [31:0]  HRUSERS;
    logic [15:0]  err_count;
    logic [21:0]  err_addr;

    int n_pass = 0;
    int n_total = 0;

    always #5 HCLK = ~HCLK;

    l1_ahb_mtx_dec_param #(
        .NPORT      (3),
        .REMAP_EN   (1'b1),
        .REMAP_PORT (1)
    ) dut (
        .HCLK            (HCLK),
        .HRESETn         (HRESETn),
        .HREADYS         (HREADYS),
        .sel_dec         (sel_dec),
        .decode_addr_dec (decode_addr_dec),
        .trans_dec       (trans_dec),
        .remap           (remap),
        .err_clr         (err_clr),
        .active_in       (active_in),
        .readyout_in     (readyout_in),
        .resp_in         (resp_in),
        .rdata_in        (rdata_in),
        .ruser_in        (ruser_in),
        .sel_out         (sel_out),
        .active_dec      (active_dec),
        .HREADYOUTS      (HREADYOUTS),
        .HRESPS          (HRESPS),
        .HRDATAS         (HRDATAS),
        .HRUSERS         (HRUSERS),
        .err_count       (err_count),
        .err_addr        (err_addr)
    );

    typedef struct {
        string       name;
        logic [21:0] addr;
        logic [1:0]  trans;
        logic        sel;
        logic        rmp;
        logic [2:0]  exp_sel;
        logic        exp_act;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else begin
            n_pass++;
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic drive(input logic [21:0] a, input logic [1:0] t, input logic s, input logic r);
        decode_addr_dec = a;
        trans_dec       = t;
        sel_dec         = s;
        HREADYS         = r;
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        // active_in[1]=0 so port-1 and default selections are distinguishable.
        vecs[0]  = '{"dec_p1_mid",    22'h080010, T_NONSEQ, 1'b1, 1'b0, 3'b010, 1'b0};
        vecs[1]  = '{"dec_p0_base",   22'h000000, T_NONSEQ, 1'b1, 1'b0, 3'b001, 1'b1};
        vecs[2]  = '{"dec_p0_limit",  22'h00003f, T_NONSEQ, 1'b1, 1'b0, 3'b001, 1'b1};
        vecs[3]  = '{"dec_gap0",      22'h000040, T_NONSEQ, 1'b1, 1'b0, 3'b000, 1'b1};
        vecs[4]  = '{"dec_below_p1",  22'h07ffff, T_NONSEQ, 1'b1, 1'b0, 3'b000, 1'b1};
        vecs[5]  = '{"dec_p1_base",   22'h080000, T_NONSEQ, 1'b1, 1'b0, 3'b010, 1'b0};
        vecs[6]  = '{"dec_p2_limit",  22'h10003f, T_NONSEQ, 1'b1, 1'b0, 3'b100, 1'b1};
        vecs[7]  = '{"dec_above_p2",  22'h100040, T_NONSEQ, 1'b1, 1'b0, 3'b000, 1'b1};
        vecs[8]  = '{"dec_top",       22'h3fffff, T_NONSEQ, 1'b1, 1'b0, 3'b000, 1'b1};
        vecs[9]  = '{"remap_on",      22'h000001, T_NONSEQ, 1'b1, 1'b1, 3'b010, 1'b0};
        vecs[10] = '{"remap_off",     22'h000001, T_NONSEQ, 1'b1, 1'b0, 3'b001, 1'b1};
        vecs[11] = '{"remap_p2",      22'h100000, T_NONSEQ, 1'b1, 1'b1, 3'b100, 1'b1};
        vecs[12] = '{"dec_nosel",     22'h080010, T_NONSEQ, 1'b0, 1'b0, 3'b000, 1'b0};
        vecs[13] = '{"idle_nohold",   22'h000000, T_IDLE,   1'b1, 1'b0, 3'b001, 1'b1};

        HRESETn     = 1'b0;
        remap       = 1'b0;
        err_clr     = 1'b0;
        active_in   = 3'b101;
        readyout_in = 3'b111;
        resp_in     = {2'b00, 2'b10, 2'b00};
        rdata_in    = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        ruser_in    = {32'hE000_0002, 32'hE000_0001, 32'hE000_0000};
        drive(22'h0, T_IDLE, 1'b0, 1'b0);

        #12;
        chk("rst_ready", 32'(HREADYOUTS), 32'd1);
        chk("rst_resp",  32'(HRESPS), 32'd0);
        chk("rst_rdata", HRDATAS, 32'd0);
        chk("rst_count", 32'(err_count), 32'd0);
        chk("rst_eaddr", 32'(err_addr), 32'd0);
        #2;
        HRESETn = 1'b1;
        tick();

        // Combinational decode table with HREADYS low, so data_port stays at default.
        for (int k = 0; k < 14; k++) begin
            drive(vecs[k].addr, vecs[k].trans, vecs[k].sel, 1'b0);
            remap = vecs[k].rmp;
            #1;
            chk({vecs[k].name, "_sel"}, 32'(sel_out), 32'(vecs[k].exp_sel));
            chk({vecs[k].name, "_act"}, 32'(active_dec), 32'(vecs[k].exp_act));
        end
        remap = 1'b0;

        // Port-1 data phase, then IDLE held on port 1.
        drive(22'h080010, T_NONSEQ, 1'b1, 1'b1);
        tick();
        drive(22'h000000, T_IDLE, 1'b0, 1'b1);
        #1;
        chk("p1_rdata", HRDATAS, 32'hD000_0001);
        chk("p1_ruser", HRUSERS, 32'hE000_0001);
        chk("p1_resp",  32'(HRESPS), 32'd2);
        chk("p1_ready", 32'(HREADYOUTS), 32'd1);
        tick();

        // Unmapped NONSEQ -> ERR1, ERR2.
        drive(22'h3fffff, T_NONSEQ, 1'b1, 1'b1);
        tick();
        drive(22'h000000, T_IDLE, 1'b0, 1'b0);
        #1;
        chk("err1_ready", 32'(HREADYOUTS), 32'd0);
        chk("err1_resp",  32'(HRESPS), 32'd1);
        chk("err1_count", 32'(err_count), 32'd1);
        chk("err1_addr",  32'(err_addr), 32'h3fffff);
        tick();
        chk("err2_ready", 32'(HREADYOUTS), 32'd1);
        chk("err2_resp",  32'(HRESPS), 32'd1);
        chk("err2_rdata", HRDATAS, 32'd0);

        // Second error accepted in ERR2 goes straight back to ERR1.
        drive(22'h3ffff0, T_NONSEQ, 1'b1, 1'b1);
        tick();
        drive(22'h000000, T_IDLE, 1'b0, 1'b0);
        #1;
        chk("b2b_ready", 32'(HREADYOUTS), 32'd0);
        chk("b2b_count", 32'(err_count), 32'd2);
        chk("b2b_addr",  32'(err_addr), 32'h3ffff0);
        tick();
        drive(22'h200000, T_NONSEQ, 1'b1, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        drive(22'h000000, T_IDLE, 1'b0, 1'b0);
        #1;
        chk("clrinc_count", 32'(err_count), 32'd1);
        chk("clrinc_addr",  32'(err_addr), 32'h200000);
        chk("clrinc_ready", 32'(HREADYOUTS), 32'd0);
        tick();
        drive(22'h000000, T_IDLE, 1'b0, 1'b1);
        tick();
        chk("post_err_resp",  32'(HRESPS), 32'd0);
        chk("post_err_rdata", HRDATAS, 32'hD000_0000);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_count", 32'(err_count), 32'd0);

        // Unselected unmapped NONSEQ and selected IDLE to default slave: OKAY, no error.
        drive(22'h3fffff, T_NONSEQ, 1'b0, 1'b1);
        tick();
        drive(22'h3fffff, T_IDLE, 1'b1, 1'b1);
        tick();
        chk("defidle_ready", 32'(HREADYOUTS), 32'd1);
        chk("defidle_resp",  32'(HRESPS), 32'd0);
        chk("defidle_count", 32'(err_count), 32'd0);

        // Hold rule: data phase on port 2, IDLE to a port-0 address stays on port 2.
        drive(22'h100000, T_NONSEQ, 1'b1, 1'b1);
        tick();
        active_in = 3'b011;
        drive(22'h000000, T_IDLE, 1'b1, 1'b1);
        #1;
        chk("hold_sel",   32'(sel_out), 32'b100);
        chk("hold_act",   32'(active_dec), 32'd0);
        chk("hold_rdata", HRDATAS, 32'hD000_0002);
        active_in = 3'b101;

        // Port 0 wait states: response stalls, data_port frozen.
        drive(22'h000010, T_NONSEQ, 1'b1, 1'b1);
        tick();
        readyout_in = 3'b110;
        drive(22'h080000, T_NONSEQ, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("wait%0d_ready", k), 32'(HREADYOUTS), 32'd0);
            chk($sformatf("wait%0d_rdata", k), HRDATAS, 32'hD000_0000);
            tick();
        end
        readyout_in = 3'b111;
        HREADYS = 1'b1;
        #1;
        chk("wait_end_ready", 32'(HREADYOUTS), 32'd1);
        tick();
        chk("wait_next_rdata", HRDATAS, 32'hD000_0001);

        // Saturation: preload the counter near full, then two more errors.
        force dut.err_count_reg = 16'hFFFE;
        #1;
        release dut.err_count_reg;
        drive(22'h3fffff, T_NONSEQ, 1'b1, 1'b1);
        tick();
        chk("sat1_count", 32'(err_count), 32'hFFFF);
        drive(22'h000000, T_IDLE, 1'b0, 1'b0);
        tick();
        drive(22'h3fffff, T_NONSEQ, 1'b1, 1'b1);
        tick();
        chk("sat2_count", 32'(err_count), 32'hFFFF);
        chk("sat2_ready", 32'(HREADYOUTS), 32'd0);

        // Asynchronous reset in the middle of ERR1.
        drive(22'h000000, T_IDLE, 1'b0, 1'b0);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("arst_ready", 32'(HREADYOUTS), 32'd1);
        chk("arst_resp",  32'(HRESPS), 32'd0);
        chk("arst_count", 32'(err_count), 32'd0);
        #2;
        HRESETn = 1'b1;
        tick();
        chk("arst_after_ready", 32'(HREADYOUTS), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/l1_ahb_mtx_dec_param.md
# l1_ahb_mtx_dec_param

Parametrised AHB-Lite bus-matrix input-stage decoder for the L1 matrix, supporting 1–8 output ports. Each port has an address region set by parameters. An optional remap input redirects the boot region to another port. The block routes data-phase responses back to the input stage, includes a built-in two-cycle ERROR default slave, and logs errors in a saturating counter with an address capture. It sits between each matrix input stage and the per-output-port bus-switch stages.

## Interface
Parameters:
- NPORT, 3: number of output ports, 1..8.
- ADDR_BASE, {22'h100000,22'h080000,22'h000000}: packed NPORT×22 region lower bounds on HADDR[31:10]; port i occupies bits [22i+21:22i].
- ADDR_LIMIT, {22'h10003f,22'h08003f,22'h00003f}: packed inclusive upper bounds. A region with BASE > LIMIT is disabled.
- REMAP_EN, 0: 1 enables the remap input.
- REMAP_PORT, 1: target port for region-0 addresses while remap is active.

Ports (reset HRESETn, asynchronous, active-low; clock HCLK):
- HCLK  in  1  AHB clock
- HRESETn  in  1  async active-low reset
- HREADYS  in  1  input-stage HREADY (transfer accepted/completed)
- sel_dec  in  1  HSEL from input stage
- decode_addr_dec  in  22  HADDR[31:10]
- trans_dec  in  2  HTRANS
- remap  in  1  region-0 redirect request
- err_clr  in  1  synchronous clear of err_count
- active_in  in  NPORT  per-port active from bus switches
- readyout_in  in  NPORT  per-port HREADYOUT
- resp_in  in  2·NPORT  per-port HRESP
- rdata_in  in  32·NPORT  per-port HRDATA
- ruser_in  in  32·NPORT  per-port HRUSER
- sel_out  out  NPORT  per-port HSEL (one-hot or zero)
- active_dec  out  1  selected port's active
- HREADYOUTS  out  1  data-phase HREADYOUT
- HRESPS  out  2  data-phase HRESP
- HRDATAS  out  32  data-phase read data
- HRUSERS  out  32  data-phase read user data
- err_count  out  16  saturating count of default-slave ERROR responses
- err_addr  out  22  HADDR[31:10] of the most recent errored transfer

## Operation
- Address decode (combinational): hit_i = BASE_i ≤ addr ≤ LIMIT_i.
  - The lowest-index hit wins.
  - When REMAP_EN and remap are both 1, a hit on region 0 selects REMAP_PORT instead of port 0.
  - No hit selects the default slave, encoded as addr_port = NPORT.
- Hold rule: if trans_dec == IDLE and data_port < NPORT, addr_port = data_port. This takes priority over the address hit.
- sel_out[addr_port] = sel_dec; all other bits are 0. The default slave is selected when sel_dec = 1 and addr_port = NPORT.
- active_dec = active_in[addr_port], or 1 when addr_port = NPORT.
- data_port register (4 bits): loads addr_port when HREADYS = 1. Reset value is NPORT (default slave).
- Data mux by data_port:
  - Port i: HREADYOUTS, HRESPS, HRDATAS and HRUSERS come from that port's inputs.
  - Default slave: the default-slave FSM outputs, with HRDATAS = HRUSERS = 0.
- Default-slave FSM states: IDLE, ERR1, ERR2.
  - IDLE → ERR1 when the default slave is selected, HREADYS = 1 and trans_dec[1] = 1 (NONSEQ or SEQ).
  - ERR1 → ERR2 unconditionally.
  - ERR2 → ERR1 if a new errored transfer is accepted in that cycle; otherwise ERR2 → IDLE.
  - Outputs: IDLE gives ready 1, resp 00. ERR1 gives ready 0, resp 01. ERR2 gives ready 1, resp 01.
  - IDLE/BUSY transfers to the default slave get a zero-wait OKAY.
- Error log: on each entry to ERR1, err_count increments (saturating at 16'hFFFF) and err_addr captures decode_addr_dec.
  - err_clr sets err_count = 0.
  - If err_clr and an increment occur in the same cycle, err_count = 1.
- Reset values: data_port = NPORT, FSM = IDLE, err_count = 0, err_addr = 0. Consequently HREADYOUTS = 1, HRESPS = 00, HRDATAS = 0, HRUSERS = 0.
  - sel_out and active_dec stay combinational from inputs during reset.

## Timing
- sel_out and active_dec: zero-cycle combinational from the address-phase inputs.
- Data-phase response: selected from data_port registered on the HCLK edge where HREADYS = 1.
- Default-slave error latency:
  - Accepting edge, then ERR1 for one cycle (HREADYOUTS = 0).
  - ERR2 for one cycle (HREADYOUTS = 1, HRESPS = 01).
  - Total of two data-phase cycles.
- err_count and err_addr are visible on the edge that enters ERR1.
- When HREADYS = 0, data_port holds its value even if the address changes.
- An HRESETn assertion during ERR1 or ERR2 returns the FSM to IDLE asynchronously; HREADYOUTS = 1 immediately.

## Test plan
- Reset then idle: HRESETn low → HREADYOUTS = 1, HRESPS = 00, err_count = 0. Next, addr 22'h080010, NONSEQ, sel = 1 → sel_out = 3'b010; data phase returns rdata_in port 1.
- Unmapped NONSEQ: addr 22'h3FFFFF, HREADYS = 1 → cycle+1: HREADYOUTS = 0, HRESPS = 01. Cycle+2: HREADYOUTS = 1, HRESPS = 01. err_count = 1, err_addr = 22'h3FFFFF.
- Back-to-back errors: second unmapped NONSEQ accepted in ERR2 → FSM goes directly to ERR1; err_count = 2. Then set err_clr = 1 in the same cycle as a third error → err_count = 1.
- Remap (REMAP_EN = 1): remap = 1, addr 22'h000001 → sel_out = 3'b010. With remap = 0 the same address → sel_out = 3'b001.
- Hold rule: data_port = 2, then trans IDLE with addr 22'h000000 → sel_out = 3'b100 and active_dec = active_in[2].
- Saturation and wait states: force 65536 errors → err_count stays 16'hFFFF. Port 0 readyout_in = 0 for 3 cycles → HREADYOUTS = 0 for 3 cycles and data_port unchanged.
